// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multicycle control FSM for the RISC-V datapath.
// Sequences FETCH/DECODE/EXEC/MEM/WB for one instruction at a time and drives
// the ALU op, operand selects and the PC/IR/regfile/memory enables.
// Optional build macro: MULTICYCLE_CTRL_TRAP_EN (illegal decode parks in TRAP
// until reset; when undefined, an illegal instruction retires as a NOP).
module multicycle_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        mem_ready,
  output logic [2:0]  alu_ctrl,
  output logic [1:0]  alu_src1,
  output logic [1:0]  alu_src2,
  output logic        pc_write,
  output logic        ir_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        reg_write,
  output logic        result_src,
  output logic        retire,
  output logic        illegal,
  output logic [3:0]  state
);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_EXEC_R   = 4'd3,
    S_EXEC_I   = 4'd4,
    S_MEM_ADDR = 4'd5,
    S_MEM_RD   = 4'd6,
    S_MEM_WR   = 4'd7,
    S_WB_ALU   = 4'd8,
    S_WB_MEM   = 4'd9,
    S_TRAP     = 4'd10
  } state_t;

  typedef enum logic [2:0] {
    C_ILL = 3'd0,
    C_R   = 3'd1,
    C_I   = 3'd2,
    C_LW  = 3'd3,
    C_SW  = 3'd4
  } cls_t;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SRL = 3'b001;
  localparam logic [2:0] OP_OR  = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;

  state_t      r_state;
  cls_t        r_cls;
  logic [2:0]  r_op;

  cls_t        w_cls;
  logic [2:0]  w_op;
  logic [6:0]  w_opcode;
  logic [2:0]  w_funct3;
  logic [6:0]  w_funct7;
  logic        w_unused_bits;

  assign w_opcode = instr[6:0];
  assign w_funct3 = instr[14:12];
  assign w_funct7 = instr[31:25];
  // Register/immediate fields are consumed by the datapath, not by control.
  assign w_unused_bits = ^{instr[24:15], instr[11:7]};

  assign state = r_state;

  // Instruction decode into op class and ALU op (used during DECODE).
  always_comb begin
    w_cls = C_ILL;
    w_op  = OP_ADD;
    unique case (w_opcode)
      7'b0110011: begin
        if (w_funct7 == 7'b0000000) begin
          unique case (w_funct3)
            3'b000:  begin w_cls = C_R; w_op = OP_ADD; end
            3'b101:  begin w_cls = C_R; w_op = OP_SRL; end
            3'b110:  begin w_cls = C_R; w_op = OP_OR;  end
            3'b111:  begin w_cls = C_R; w_op = OP_AND; end
            default: begin w_cls = C_ILL; w_op = OP_ADD; end
          endcase
        end
      end
      7'b0010011: begin
        unique case (w_funct3)
          3'b000:  begin w_cls = C_I; w_op = OP_ADD; end
          3'b110:  begin w_cls = C_I; w_op = OP_OR;  end
          3'b111:  begin w_cls = C_I; w_op = OP_AND; end
          3'b101: begin
            if (w_funct7 == 7'b0000000) begin
              w_cls = C_I;
              w_op  = OP_SRL;
            end
          end
          default: begin w_cls = C_ILL; w_op = OP_ADD; end
        endcase
      end
      7'b0000011: if (w_funct3 == 3'b010) w_cls = C_LW;
      7'b0100011: if (w_funct3 == 3'b010) w_cls = C_SW;
      default:    w_cls = C_ILL;
    endcase
  end

  // State register plus op class / ALU op latched at the end of DECODE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cls   <= C_ILL;
      r_op    <= '0;
    end else begin
      unique case (r_state)
        S_IDLE:  r_state <= S_FETCH;
        S_FETCH: if (mem_ready) r_state <= S_DECODE;
        S_DECODE: begin
          r_cls <= w_cls;
          r_op  <= w_op;
          unique case (w_cls)
            C_R:        r_state <= S_EXEC_R;
            C_I:        r_state <= S_EXEC_I;
            C_LW, C_SW: r_state <= S_MEM_ADDR;
            default: begin
`ifdef MULTICYCLE_CTRL_TRAP_EN
              r_state <= S_TRAP;
`else
              r_state <= S_FETCH;
`endif
            end
          endcase
        end
        S_EXEC_R:   r_state <= S_WB_ALU;
        S_EXEC_I:   r_state <= S_WB_ALU;
        S_MEM_ADDR: r_state <= (r_cls == C_SW) ? S_MEM_WR : S_MEM_RD;
        S_MEM_RD:   if (mem_ready) r_state <= S_WB_MEM;
        S_MEM_WR:   if (mem_ready) r_state <= S_FETCH;
        S_WB_ALU:   r_state <= S_FETCH;
        S_WB_MEM:   r_state <= S_FETCH;
`ifdef MULTICYCLE_CTRL_TRAP_EN
        S_TRAP:     r_state <= S_TRAP;
`endif
        default:    r_state <= S_IDLE;
      endcase
    end
  end

  // Moore output decode; the handshake only qualifies the completing strobes
  // (FETCH ir/pc write, MEM_WR retire) and DECODE flags an illegal NOP.
  always_comb begin
    alu_ctrl   = OP_ADD;
    alu_src1   = 2'd0;
    alu_src2   = 2'd0;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    result_src = 1'b0;
    retire     = 1'b0;
    illegal    = 1'b0;
    unique case (r_state)
      S_FETCH: begin
        mem_read = 1'b1;
        alu_src1 = 2'd0;
        alu_src2 = 2'd2;
        ir_write = mem_ready;
        pc_write = mem_ready;
      end
      S_DECODE: begin
        alu_src1 = 2'd2;
        alu_src2 = 2'd1;
`ifndef MULTICYCLE_CTRL_TRAP_EN
        if (w_cls == C_ILL) begin
          retire  = 1'b1;
          illegal = 1'b1;
        end
`endif
      end
      S_EXEC_R: begin
        alu_src1 = 2'd1;
        alu_src2 = 2'd0;
        alu_ctrl = r_op;
      end
      S_EXEC_I: begin
        alu_src1 = 2'd1;
        alu_src2 = 2'd1;
        alu_ctrl = r_op;
      end
      S_MEM_ADDR: begin
        alu_src1 = 2'd1;
        alu_src2 = 2'd1;
      end
      S_MEM_RD: mem_read = 1'b1;
      S_MEM_WR: begin
        mem_write = 1'b1;
        retire    = mem_ready;
      end
      S_WB_ALU: begin
        reg_write = 1'b1;
        retire    = 1'b1;
      end
      S_WB_MEM: begin
        reg_write  = 1'b1;
        result_src = 1'b1;
        retire     = 1'b1;
      end
`ifdef MULTICYCLE_CTRL_TRAP_EN
      S_TRAP: illegal = 1'b1;
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: walks add, srli, lw (with memory wait),
// sw, an illegal sub and a mid-instruction reset, checking every step.
module tb_multicycle_ctrl;

  logic        clk;
  logic        rst_n;
  logic [31:0] instr;
  logic        mem_ready;
  logic [2:0]  alu_ctrl;
  logic [1:0]  alu_src1;
  logic [1:0]  alu_src2;
  logic        pc_write;
  logic        ir_write;
  logic        mem_read;
  logic        mem_write;
  logic        reg_write;
  logic        result_src;
  logic        retire;
  logic        illegal;
  logic [3:0]  state;

  int n_tests = 0;
  int n_fail  = 0;
  int retire_cnt = 0;

  multicycle_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .instr     (instr),
    .mem_ready (mem_ready),
    .alu_ctrl  (alu_ctrl),
    .alu_src1  (alu_src1),
    .alu_src2  (alu_src2),
    .pc_write  (pc_write),
    .ir_write  (ir_write),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .reg_write (reg_write),
    .result_src(result_src),
    .retire    (retire),
    .illegal   (illegal),
    .state     (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Retire pulses seen at each active edge.
  always @(posedge clk) if (retire === 1'b1) retire_cnt++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle away from the edge.
  task automatic adv;
    @(posedge clk);
    #2;
  endtask

  function automatic logic [14:0] all_outs();
    return {alu_ctrl, alu_src1, alu_src2, pc_write, ir_write, mem_read,
            mem_write, reg_write, result_src, retire, illegal};
  endfunction

  initial begin
    rst_n     = 1'b0;
    instr     = 32'h0000_0013;
    mem_ready = 1'b1;

    // Reset state
    #12;
    chk("rst_state", {28'd0, state}, 32'd0);
    chk("rst_outs", {17'd0, all_outs()}, 32'd0);
    #5 rst_n = 1'b1;                       // released between edges
    adv;
    chk("rel_fetch", {28'd0, state}, 32'd1);
    chk("fetch_outs", {17'd0, all_outs()}, {17'd0, 3'b000, 2'd0, 2'd2, 8'b1110_0000});

    // add a0,a0,a1
    instr = 32'h00B5_0533;
    adv;
    chk("add_dec", {28'd0, state}, 32'd2);
    chk("add_dec_src", {28'd0, alu_src1, alu_src2}, {28'd0, 2'd2, 2'd1});
    chk("add_dec_ret", {30'd0, retire, illegal}, 32'd0);
    adv;
    chk("add_exec", {28'd0, state}, 32'd3);
    chk("add_exec_alu", {25'd0, alu_ctrl, alu_src1, alu_src2}, {25'd0, 3'b000, 2'd1, 2'd0});
    adv;
    chk("add_wb", {28'd0, state}, 32'd8);
    chk("add_wb_ret", {29'd0, reg_write, result_src, retire}, {29'd0, 3'b101});
    adv;
    chk("add_next", {28'd0, state}, 32'd1);
    chk("add_next_ret", {31'd0, retire}, 32'd0);

    // srli a0,a1,5
    instr = 32'h0055_D513;
    adv;
    chk("srli_dec", {28'd0, state}, 32'd2);
    adv;
    chk("srli_exec", {28'd0, state}, 32'd4);
    chk("srli_alu", {25'd0, alu_ctrl, alu_src1, alu_src2}, {25'd0, 3'b001, 2'd1, 2'd1});
    adv;
    chk("srli_wb", {28'd0, state, retire}, {27'd0, 4'd8, 1'b1});
    adv;
    chk("srli_next", {28'd0, state}, 32'd1);

    // lw with three memory wait cycles
    instr = 32'h0004_A503;
    adv;
    chk("lw_dec", {28'd0, state}, 32'd2);
    adv;
    chk("lw_addr", {28'd0, state}, 32'd5);
    chk("lw_addr_alu", {25'd0, alu_ctrl, alu_src1, alu_src2}, {25'd0, 3'b000, 2'd1, 2'd1});
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      adv;
      chk("lw_wait", {28'd0, state, mem_read}, {27'd0, 4'd6, 1'b1});
      chk("lw_wait_ret", {30'd0, retire, reg_write}, 32'd0);
    end
    adv;
    chk("lw_rd_last", {28'd0, state}, 32'd6);
    mem_ready = 1'b1;
    adv;
    chk("lw_wb", {28'd0, state}, 32'd9);
    chk("lw_wb_outs", {29'd0, reg_write, result_src, retire}, {29'd0, 3'b111});
    adv;
    chk("lw_next", {28'd0, state}, 32'd1);

    // sw
    instr = 32'h00A4_A023;
    adv;
    chk("sw_dec", {28'd0, state}, 32'd2);
    adv;
    chk("sw_addr", {28'd0, state, reg_write}, {27'd0, 4'd5, 1'b0});
    adv;
    chk("sw_wr", {28'd0, state}, 32'd7);
    chk("sw_wr_outs", {29'd0, mem_write, retire, reg_write}, {29'd0, 3'b110});
    adv;
    chk("sw_next", {28'd0, state, retire}, {27'd0, 4'd1, 1'b0});
    chk("sw_next_mw", {31'd0, mem_write}, 32'd0);

    // sub (illegal)
    instr = 32'h40B5_0533;
    adv;
`ifdef MULTICYCLE_CTRL_TRAP_EN
    chk("sub_dec", {28'd0, state, retire}, {27'd0, 4'd2, 1'b0});
    for (int i = 0; i < 20; i++) begin
      adv;
      chk("sub_trap", {28'd0, state, illegal}, {27'd0, 4'd10, 1'b1});
      chk("sub_trap_en", {17'd0, all_outs()}, 32'd1);
    end
`else
    chk("sub_dec", {28'd0, state}, 32'd2);
    chk("sub_nop", {30'd0, retire, illegal}, 32'd3);
    adv;
    chk("sub_next", {28'd0, state}, 32'd1);
    chk("sub_next_flags", {30'd0, retire, illegal}, 32'd0);
`endif

    // Reset to a known point, then abort a lw in MEM_RD
    rst_n = 1'b0;
    #1;
    chk("rst2_state", {28'd0, state}, 32'd0);
    adv;
    rst_n = 1'b1;
    instr = 32'h0004_A503;
    mem_ready = 1'b1;
    adv;
    chk("ab_fetch", {28'd0, state}, 32'd1);
    adv;
    chk("ab_dec", {28'd0, state}, 32'd2);
    adv;
    chk("ab_addr", {28'd0, state}, 32'd5);
    mem_ready = 1'b0;
    adv;
    chk("ab_rd", {28'd0, state, mem_read}, {27'd0, 4'd6, 1'b1});
    #1 rst_n = 1'b0;
    #1;
    chk("ab_rst_state", {28'd0, state}, 32'd0);
    chk("ab_rst_outs", {17'd0, all_outs()}, 32'd0);
    mem_ready = 1'b1;
    adv;
    chk("ab_hold", {28'd0, state}, 32'd0);
    rst_n = 1'b1;
    adv;
    chk("ab_refetch", {28'd0, state, retire}, {27'd0, 4'd1, 1'b0});

    // add, srli, lw, sw retire; the illegal NOP retires only without TRAP
`ifdef MULTICYCLE_CTRL_TRAP_EN
    chk("retire_count", retire_cnt, 32'd4);
`else
    chk("retire_count", retire_cnt, 32'd5);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Hard time limit so the bench always terminates.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multicycle control FSM that sits directly upstream of the 4-bit-parameterised ALU in the RISCV microarchitecture. It sequences fetch, decode, execute, memory and writeback for one instruction at a time. It drives the ALU's 3-bit operation code and both operand-source selects, plus the PC, IR, register-file and memory enables. It covers the ALU's operation set: add, srl, or, and, in R-type and I-type form, plus lw and sw.

## Interface
- No parameters; all widths fixed.
- clk  in  1  single clock, rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- instr  in  32  current instruction from the IR; sampled in DECODE.
- mem_ready  in  1  memory handshake; completes the current FETCH, MEM_RD or MEM_WR access.
- alu_ctrl  out  3  ALU op to the ALU OP input: 000 add, 001 srl, 010 or, 011 and.
- alu_src1  out  2  operand-1 mux select: 0 pc, 1 rs1, 2 old_pc.
- alu_src2  out  2  operand-2 mux select: 0 rs2, 1 imm, 2 constant 4.
- pc_write  out  1  load PC with ALU result.
- ir_write  out  1  load IR from memory data.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- reg_write  out  1  register-file write enable.
- result_src  out  1  writeback select: 0 ALU result, 1 memory data.
- retire  out  1  one-cycle pulse in the final state of each instruction.
- illegal  out  1  illegal-instruction flag.
- state  out  4  current state encoding, for debug and the bench.

## Operation
- States and encodings: IDLE 0, FETCH 1, DECODE 2, EXEC_R 3, EXEC_I 4, MEM_ADDR 5, MEM_RD 6, MEM_WR 7, WB_ALU 8, WB_MEM 9, TRAP 10.
- Outputs are Moore: decoded only from `state` and the fields latched in DECODE.
- IDLE:
  - All outputs 0.
  - Moves to FETCH unconditionally on the next edge.
- FETCH:
  - Drives mem_read=1, alu_src1=0, alu_src2=2, alu_ctrl=000.
  - When mem_ready=1, also drives ir_write=1 and pc_write=1, and moves to DECODE.
  - Otherwise holds with ir_write=0 and pc_write=0.
- DECODE:
  - Latches the op class and the ALU op from instr.
  - Drives alu_src1=2, alu_src2=1, alu_ctrl=000 for a speculative target add.
  - Next state by instruction: R-type to EXEC_R; I-ALU to EXEC_I; lw/sw to MEM_ADDR; otherwise illegal.
- Legal decodes:
  - opcode 0110011 (R-type), funct7=0000000, funct3 000/101/110/111 → alu_ctrl 000/001/010/011.
  - opcode 0010011 (I-ALU), funct3 000/110/111 → alu_ctrl 000/010/011; funct3 101 is legal only with instr[31:25]=0 → 001.
  - opcode 0000011 with funct3 010 (lw); opcode 0100011 with funct3 010 (sw).
  - Everything else is illegal, including sub, sra, slt, xor, sll, byte/half loads and stores, branches, and jumps.
- EXEC_R: alu_src1=1, alu_src2=0, alu_ctrl=latched op; moves to WB_ALU.
- EXEC_I: alu_src1=1, alu_src2=1, alu_ctrl=latched op; moves to WB_ALU.
- MEM_ADDR: alu_src1=1, alu_src2=1, alu_ctrl=000; moves to MEM_RD for lw, MEM_WR for sw.
- MEM_RD: mem_read=1; holds until mem_ready=1, then moves to WB_MEM.
- MEM_WR: mem_write=1 and retire=1 on the mem_ready cycle; holds until mem_ready=1, then moves to FETCH.
- WB_ALU: reg_write=1, result_src=0, retire=1; moves to FETCH.
- WB_MEM: reg_write=1, result_src=1, retire=1; moves to FETCH.
- alu_ctrl is held stable for the whole EXEC/MEM_ADDR state. Outside the states that drive it, alu_ctrl is 000.
- mem_ready is ignored in every state except FETCH, MEM_RD and MEM_WR.

## Timing
- Reset (asynchronous assert): state=IDLE immediately; every output 0, including illegal.
- Reset release: the first edge goes to FETCH. Reset asserted mid-instruction aborts it and produces no retire.
- Cycle counts with zero memory wait:
  - R-type and I-ALU: 4 cycles (FETCH, DECODE, EXEC, WB).
  - lw: 5 cycles.
  - sw: 4 cycles.
- Each memory wait cycle adds exactly one cycle in FETCH, MEM_RD or MEM_WR.
- retire pulses exactly once per completed instruction and is never high in two consecutive cycles.

## Configuration
- MULTICYCLE_CTRL_TRAP_EN defined:
  - An illegal decode goes DECODE→TRAP.
  - TRAP drives illegal=1, all enables 0 and retire=0.
  - TRAP holds until reset.
- MULTICYCLE_CTRL_TRAP_EN undefined:
  - An illegal decode goes DECODE→FETCH and the instruction is treated as a NOP.
  - That NOP pulses retire=1 and illegal=1 for the single DECODE cycle.
  - TRAP is unreachable.

## Test plan
- instr=0x00B50533 (add a0,a0,a1), mem_ready tied 1 → states 1,2,3,8,1; alu_ctrl=000 with alu_src1=1, alu_src2=0 in EXEC_R; reg_write=1 and retire=1 in WB_ALU.
- instr=0x0055D513 (srli a0,a1,5) → EXEC_I with alu_ctrl=001, alu_src2=1; 4 cycles to retire.
- instr=0x0004A503 (lw), mem_ready low for 3 cycles in MEM_RD → 3 extra MEM_RD cycles; then WB_MEM with result_src=1; total 8 cycles.
- instr=0x00A4A023 (sw), mem_ready=1 → MEM_WR with mem_write=1 and retire=1 for one cycle; reg_write never asserted.
- instr=0x40B50533 (sub):
  - With MULTICYCLE_CTRL_TRAP_EN: state=10, illegal=1 holds for 20 cycles.
  - Without it: retire=1 and illegal=1 for one cycle, then state=1.
- rst_n pulled low during MEM_RD → same cycle state=0 and all outputs 0; after release, IDLE→FETCH and no retire for the aborted lw.
